exec_seq: RTL
=============

EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 instr / instr_valid / instr_ready  in 32 / in 1 / out 1  instruction word with valid/ready handshake.
REQ-004 rs1, rs2, rd  out  5 each  register-file addresses from the latched instruction.
REQ-005 imm  out  32  sign-extended immediate (I- or B-format).
REQ-006 a_sel_pc, b_sel_imm  out  1 each  ALU operand muxes: a = PC, b = imm.
REQ-007 alu_op  out  3  ALU operation code: ADD=000 SL=001 SLT=010 SLTU=011 XOR=100 SR=101 OR=110 AND=111.
REQ-008 alu_sub_en, alu_sra_en, alu_bus_en, alu_addr_en  out  1 each  ALU modifiers and output enables.
REQ-009 alu_eq, alu_lt, alu_ltu, alu_ge, alu_geu  in  1 each  ALU compare flags.
REQ-010 rd_we  out  1  register write strobe for the ALU result on the bus.
REQ-011 pc_load  out  1  PC loads from addr bus this cycle.
REQ-012 illegal  out  1  one-cycle pulse for an unsupported instruction.

Function
REQ-013 FSM states: IDLE, DECODE, EXEC, BRTGT.
REQ-014 IDLE: instr_ready = 1 in IDLE only; instr_valid && instr_ready latches instr, next state DECODE.
REQ-015 DECODE: drives rs1/rs2/imm from the latched word, all enables 0, 1 cycle.
  - Legal -> EXEC.
  - Illegal -> illegal = 1 that cycle, then IDLE.
REQ-016 Legal opcodes: OP 0110011, OP-IMM 0010011, BRANCH 1100011; all others are illegal.
REQ-017 OP rule: funct7 must be 0000000, or 0100000 only with funct3 000/101.
  - alu_sub_en = funct3==000 && funct7[5].
  - alu_sra_en = funct3==101 && funct7[5].
REQ-018 OP-IMM rule: b_sel_imm = 1; alu_sub_en = 0; alu_op = funct3.
  - funct3 001 requires imm[11:5] = 0000000.
  - funct3 101 allows 0000000 or 0100000; alu_sra_en = imm[10].
REQ-019 EXEC for OP/OP-IMM: alu_bus_en = 1; rd_we = (rd != 0); next state IDLE.
REQ-020 BRANCH rule: funct3 010/011 are illegal.
  - EXEC samples the flags: taken = BEQ eq, BNE !eq, BLT lt, BGE ge, BLTU ltu, BGEU geu.
  - Taken is registered; next state BRTGT.
REQ-021 BRTGT: a_sel_pc = 1, b_sel_imm = 1, alu_op = ADD, alu_addr_en = 1, pc_load = taken_q; next state IDLE.
REQ-022 Latency from handshake edge: ALU ops 3 cycles to the IDLE return; branches 4 cycles.
REQ-023 Outputs are decoded from state plus latched instruction only; never from live instr.
REQ-024 Only one of alu_bus_en / alu_addr_en may be high in any cycle; rd_we and pc_load are never both high.
REQ-025 instr_valid held high across busy states is ignored, with no new latch until IDLE.

Reset
REQ-026 rst_n low: state = IDLE immediately; latched instr = 0; taken_q = 0.
  - All strobes/enables = 0, instr_ready = 1.
  - Applies mid-operation; no partial rd_we or pc_load after release.
REQ-027 The first handshake is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package rv_pkg holds the opcode constants, the ALU op enum, and the FSM state enum.
REQ-029 The immediate generator (I/B formats) is sub-module imm_gen; everything else is inline.

Verification
REQ-030 ADD x3,x1,x2 (0x002081B3) -> EXEC: alu_op=000, sub=0, bus_en=1, rd=3, rd_we=1; ready again at cycle 3.
REQ-031 SUB 0x402081B3 -> sub_en=1; SRAI x5,x6,4 (0x40435293) -> op=101, sra_en=1, b_sel_imm=1, imm=4.
REQ-032 BEQ x1,x2,+8 (0x00208463):
  - alu_eq=1 -> BRTGT with imm=8, addr_en=1, pc_load=1.
  - alu_eq=0 -> pc_load=0.
REQ-033 ADDI x0,x0,0 (0x00000013) -> bus_en=1, rd_we=0.
  - 0x0000007F -> illegal pulse in DECODE, no enables, IDLE next.
REQ-034 rst_n low during EXEC of ADD -> rd_we drops asynchronously, instr_ready=1.
  - instr_valid held through a branch -> exactly one accept.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the execution sequencer: opcode constants, ALU
// operation codes, FSM state encoding and the instruction legality check.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SL   = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_BRTGT  = 2'd3
  } state_e;

  // Supported subset: register ALU ops, immediate ALU ops, conditional branches.
  function automatic logic is_legal(input logic [31:0] instr);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    ok  = 1'b0;
    case (opc)
      OPC_OP:
        ok = (f7 == 7'b0000000) ||
             ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_OPIMM: begin
        if (f3 == 3'b001)      ok = (f7 == 7'b0000000);
        else if (f3 == 3'b101) ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   ok = 1'b1;
      end
      OPC_BRANCH:
        ok = (f3 != 3'b010) && (f3 != 3'b011);
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/exec_seq_if.sv
// Instruction handshake between an instruction source (master) and the
// execution sequencer (slave).
//   instr        32-bit instruction word
//   instr_valid  source has a word available
//   instr_ready  sequencer can accept a word this cycle
interface exec_seq_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/imm_gen.sv
// Immediate generator for the latched instruction.
//   i_opcode  opcode field
//   i_funct3  funct3 field
//   i_hi      instr[31:20]
//   i_lo      instr[11:7]
//   o_imm     sign-extended I or B immediate; shift-immediates yield the
//             zero-extended shift amount so funct7 bits do not leak into it
module imm_gen
  import rv_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_hi,
  input  logic [4:0]  i_lo,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = {{20{i_hi[11]}}, i_hi};
    if (i_opcode == OPC_BRANCH) begin
      // imm[12|10:5] from instr[31:25], imm[11] from instr[7], imm[4:1] from instr[11:8]
      o_imm = {{20{i_hi[11]}}, i_lo[0], i_hi[10:5], i_lo[4:1], 1'b0};
    end else if ((i_opcode == OPC_OPIMM) &&
                 ((i_funct3 == 3'b001) || (i_funct3 == 3'b101))) begin
      o_imm = {27'd0, i_hi[4:0]};
    end
  end

endmodule

// File: rtl/exec_seq.sv
// Execution sequencer: accepts one instruction at a time, decodes it and
// drives ALU / register-file / PC control for one ALU op or one branch.
//   clk, rst_n            system clock, async active-low reset
//   bus                   instruction handshake (slave side)
//   rs1, rs2, rd, imm     operand fields of the latched instruction
//   a_sel_pc, b_sel_imm   ALU operand selects
//   alu_op, alu_*_en      ALU operation, modifiers and output enables
//   alu_eq .. alu_geu     ALU compare flags
//   rd_we, pc_load        write strobes
//   illegal               one-cycle pulse for unsupported instructions
//
// state  | meaning
// IDLE   | ready for a new instruction
// DECODE | fields presented, legality checked
// EXEC   | ALU op driven to the bus, or branch flags sampled
// BRTGT  | branch target computed on the address bus, PC loaded if taken
module exec_seq
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  exec_seq_if.slave   bus,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        a_sel_pc,
  output logic        b_sel_imm,
  output logic [2:0]  alu_op,
  output logic        alu_sub_en,
  output logic        alu_sra_en,
  output logic        alu_bus_en,
  output logic        alu_addr_en,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic        alu_ge,
  input  logic        alu_geu,
  output logic        rd_we,
  output logic        pc_load,
  output logic        illegal
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_instr;
  logic        r_taken;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_legal;
  logic        w_is_op;
  logic        w_is_opimm;
  logic        w_is_branch;
  logic        w_br_cond;

  assign w_opcode    = r_instr[6:0];
  assign w_funct3    = r_instr[14:12];
  assign w_legal     = is_legal(r_instr);
  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_is_opimm  = (w_opcode == OPC_OPIMM);
  assign w_is_branch = (w_opcode == OPC_BRANCH);

  assign rs1 = r_instr[19:15];
  assign rs2 = r_instr[24:20];
  assign rd  = r_instr[11:7];

  imm_gen u_imm_gen (
    .i_opcode (w_opcode),
    .i_funct3 (w_funct3),
    .i_hi     (r_instr[31:20]),
    .i_lo     (r_instr[11:7]),
    .o_imm    (imm)
  );

  always_comb begin
    case (w_funct3)
      3'b000:  w_br_cond = alu_eq;
      3'b001:  w_br_cond = !alu_eq;
      3'b100:  w_br_cond = alu_lt;
      3'b101:  w_br_cond = alu_ge;
      3'b110:  w_br_cond = alu_ltu;
      3'b111:  w_br_cond = alu_geu;
      default: w_br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_instr <= 32'd0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && bus.instr_valid) begin
        r_instr <= bus.instr;
      end
      if ((r_state == ST_EXEC) && w_is_branch) begin
        r_taken <= w_br_cond;
      end
    end
  end

  // All controls come from the state and the latched word, never live instr.
  always_comb begin
    w_next          = r_state;
    bus.instr_ready = 1'b0;
    a_sel_pc        = 1'b0;
    b_sel_imm       = 1'b0;
    alu_op          = ALU_ADD;
    alu_sub_en      = 1'b0;
    alu_sra_en      = 1'b0;
    alu_bus_en      = 1'b0;
    alu_addr_en     = 1'b0;
    rd_we           = 1'b0;
    pc_load         = 1'b0;
    illegal         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_legal) begin
          w_next = ST_EXEC;
        end else begin
          illegal = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (w_is_branch) begin
          w_next = ST_BRTGT;
        end else begin
          // Only legal OP / OP-IMM words reach here.
          w_next     = ST_IDLE;
          alu_op     = alu_op_e'(w_funct3);
          b_sel_imm  = w_is_opimm;
          alu_sub_en = w_is_op && (w_funct3 == 3'b000) && r_instr[30];
          alu_sra_en = (w_funct3 == 3'b101) && r_instr[30];
          alu_bus_en = 1'b1;
          rd_we      = (rd != 5'd0);
        end
      end
      ST_BRTGT: begin
        a_sel_pc    = 1'b1;
        b_sel_imm   = 1'b1;
        alu_op      = ALU_ADD;
        alu_addr_en = 1'b1;
        pc_load     = r_taken;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
